// File: rtl/code_checker.sv
// Keypad code checker: master/user code verification and two-entry user enrollment.
// Optional lockout after MAX_FAILS consecutive failed checks when CODE_CHECKER_LOCKOUT_EN is defined.
module code_checker #(
    parameter int unsigned           N_DIGITS       = 6,
    parameter logic [4*N_DIGITS-1:0] MASTER_CODE    = 24'h455612,
    parameter logic [4*N_DIGITS-1:0] USER_INIT      = 24'h666666,
    parameter logic [3:0]            CLR_KEY        = 4'd7,
    parameter logic [3:0]            ENT_KEY        = 4'd8,
    parameter int unsigned           MAX_FAILS      = 3,
    parameter int unsigned           LOCKOUT_CYCLES = 1000
) (
    input  logic                    hwclk,
    input  logic                    rst_n,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic [1:0]              mode,
    output logic                    result_valid,
    output logic                    result_ok,
    output logic [3:0]              digit_cnt,
    output logic                    enroll_pend,
    output logic                    locked,
    output logic [4*N_DIGITS-1:0]   user_code
);
    localparam int unsigned W        = 4 * N_DIGITS;
    localparam logic [3:0]  FULL_CNT = 4'(N_DIGITS);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ENTRY   = 2'd1;
    localparam logic [1:0] CONFIRM = 2'd2;
    localparam logic [1:0] LOCKOUT = 2'd3;

    logic [1:0]   state_q, state_d, state_nx;
    logic [W-1:0] buf_q, buf_d;
    logic [W-1:0] pend_q, pend_d;
    logic [W-1:0] user_q, user_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [1:0]   mode_q;
    logic         rv_q, rv_d;
    logic         ok_q, ok_d;
    logic         pflag_q, pflag_d;

    logic is_clr, is_ent, is_digit, full, mode_chg, take_key;
    logic check_pass, check_fail;

    assign is_clr   = (key_code == CLR_KEY);
    assign is_ent   = (key_code == ENT_KEY);
    assign is_digit = (key_code <= 4'd9) && !is_clr && !is_ent;
    assign full     = (cnt_q == FULL_CNT);
    // A mode switch mid-operation wins over any key arriving in the same cycle.
    assign mode_chg = ((state_q == ENTRY) || (state_q == CONFIRM)) && (mode != mode_q);
    assign take_key = key_valid && (state_q != LOCKOUT) && !mode_chg;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pflag_d    = pflag_q;
        user_d     = user_q;
        rv_d       = 1'b0;
        ok_d       = ok_q;
        check_pass = 1'b0;
        check_fail = 1'b0;
        if (mode_chg || (take_key && is_clr)) begin
            buf_d = '0;
            cnt_d = '0;
            if (state_q == CONFIRM) begin
                pflag_d = 1'b0;
                state_d = IDLE;
            end
        end else if (take_key && is_ent) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
            if (state_q == CONFIRM) begin
                rv_d    = 1'b1;
                ok_d    = full && (buf_q == pend_q);
                pflag_d = 1'b0;
                if (ok_d) begin
                    user_d = buf_q;
                end
            end else begin
                unique case (mode)
                    2'b00: begin
                        rv_d       = 1'b1;
                        ok_d       = full && (buf_q == MASTER_CODE);
                        check_pass = ok_d;
                        check_fail = !ok_d;
                    end
                    2'b01: begin
                        rv_d       = 1'b1;
                        ok_d       = full && (buf_q == user_q);
                        check_pass = ok_d;
                        check_fail = !ok_d;
                    end
                    2'b10: begin
                        if (full) begin
                            pend_d  = buf_q;
                            pflag_d = 1'b1;
                            state_d = CONFIRM;
                        end else begin
                            rv_d = 1'b1;
                            ok_d = 1'b0;
                        end
                    end
                    default: begin
                        rv_d = 1'b1;
                        ok_d = 1'b0;
                    end
                endcase
            end
        end else if (take_key && is_digit) begin
            buf_d = {buf_q[W-5:0], key_code};
            if (!full) begin
                cnt_d = cnt_q + 4'd1;
            end
            if (state_q == IDLE) begin
                state_d = ENTRY;
            end
        end
    end

`ifdef CODE_CHECKER_LOCKOUT_EN
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);

    logic [FW-1:0] fails_q, fails_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          lock_go, lock_done;

    always_comb begin
        fails_d   = fails_q;
        timer_d   = timer_q;
        lock_go   = 1'b0;
        lock_done = 1'b0;
        if (state_q == LOCKOUT) begin
            if (timer_q == '0) begin
                lock_done = 1'b1;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end else if (check_pass) begin
            fails_d = '0;
        end else if (check_fail) begin
            if (fails_q == FW'(MAX_FAILS - 1)) begin
                fails_d = '0;
                timer_d = TW'(LOCKOUT_CYCLES - 1);
                lock_go = 1'b1;
            end else begin
                fails_d = fails_q + 1'b1;
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            fails_q <= '0;
            timer_q <= '0;
        end else begin
            fails_q <= fails_d;
            timer_q <= timer_d;
        end
    end

    assign state_nx = lock_go ? LOCKOUT : (lock_done ? IDLE : state_d);
    assign locked   = (state_q == LOCKOUT);
`else
    logic unused_cfg;
    assign unused_cfg = ^{MAX_FAILS, LOCKOUT_CYCLES, check_pass, check_fail};
    assign state_nx   = state_d;
    assign locked     = 1'b0;
`endif

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            pend_q  <= '0;
            user_q  <= USER_INIT;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            rv_q    <= 1'b0;
            ok_q    <= 1'b0;
            pflag_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            user_q  <= user_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode;
            rv_q    <= rv_d;
            ok_q    <= ok_d;
            pflag_q <= pflag_d;
        end
    end

    assign result_valid = rv_q;
    assign result_ok    = ok_q;
    assign digit_cnt    = cnt_q;
    assign enroll_pend  = pflag_q;
    assign user_code    = user_q;
endmodule
